// File: rtl/rmcp_frame_ctrl_if.sv
// Sample-stream bundle between frame sync and the CP remover/framer.
// The master side drives samples and framing controls. The slave side returns the FFT window stream.
interface rmcp_frame_ctrl_if #(
  parameter int pDAT_W = 12,
  parameter int pADV_W = 6
);
  logic                     ival;
  logic                     isop;
  logic signed [pDAT_W-1:0] idata_i;
  logic signed [pDAT_W-1:0] idata_q;
  logic [1:0]               index_bw;
  logic [pADV_W-1:0]        iadv;
  logic                     oval;
  logic                     osop;
  logic                     oeop;
  logic signed [pDAT_W-1:0] odata_i;
  logic signed [pDAT_W-1:0] odata_q;
  logic [6:0]               osym_idx;
  logic                     oframe_done;
  logic                     oresync;

  modport master (
    output ival, isop, idata_i, idata_q, index_bw, iadv,
    input  oval, osop, oeop, odata_i, odata_q, osym_idx, oframe_done, oresync
  );

  modport slave (
    input  ival, isop, idata_i, idata_q, index_bw, iadv,
    output oval, osop, oeop, odata_i, odata_q, osym_idx, oframe_done, oresync
  );
endinterface

// File: rtl/rmcp_frame_ctrl.sv
// Cyclic-prefix removal and symbol framer: strips CP from each OFDM symbol of a frame
// and forwards the (optionally advanced) FFT window with SOP/EOP/symbol-index tags.
module rmcp_frame_ctrl #(
  parameter int pDAT_W    = 12,
  parameter int pNFFT_MAX = 1024,
  parameter int pCP_MAX   = 32,
  parameter int pSB_NUM   = 50,
  parameter int pADV_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  rmcp_frame_ctrl_if.slave   bus
);
  localparam int NW  = $clog2(pNFFT_MAX) + 1;
  localparam int CW0 = $clog2(pCP_MAX) + 1;
  localparam int AW  = (pADV_W > CW0) ? pADV_W : CW0;
  localparam logic [NW-1:0] N_ONE    = NW'(1);
  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [6:0]    SYM_LAST = 7'(pSB_NUM - 1);

  typedef enum logic [1:0] {IDLE, HEAD, PASS, TAIL} state_t;

  state_t             state_reg;
  logic [NW-1:0]      cnt_reg;
  logic [NW-1:0]      nfft_reg;
  logic [AW-1:0]      cp_reg;
  logic [AW-1:0]      adv_reg;
  logic [6:0]         sym_reg;
  logic               done_pend_reg;
  logic               oval_reg, osop_reg, oeop_reg, oframe_done_reg, oresync_reg;
  logic [pDAT_W-1:0]  odata_i_reg, odata_q_reg;
  logic [6:0]         osym_idx_reg;

  logic [NW-1:0]      nfft_in, cnt_inc;
  logic [AW-1:0]      cp_in, iadv_ext, adv_in, head_in, head_len;
  logic               accept, last_head, last_pass, last_tail, sym_end;

  // Geometry that a new frame would use if the current sample is an accepted isop.
  assign nfft_in  = NW'(pNFFT_MAX >> bus.index_bw);
  assign cp_in    = AW'(pCP_MAX >> bus.index_bw);
  assign iadv_ext = AW'(bus.iadv);
  assign adv_in   = (iadv_ext > cp_in) ? cp_in : iadv_ext;
  assign head_in  = cp_in - adv_in;

  assign accept    = bus.ival & bus.isop;
  assign head_len  = cp_reg - adv_reg;
  assign cnt_inc   = cnt_reg + N_ONE;
  assign last_head = (cnt_inc == NW'(head_len));
  assign last_pass = (cnt_inc == nfft_reg);
  assign last_tail = (cnt_inc == NW'(adv_reg));
  assign sym_end   = ((state_reg == PASS) && last_pass && (adv_reg == '0)) ||
                     ((state_reg == TAIL) && last_tail);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      nfft_reg        <= '0;
      cp_reg          <= '0;
      adv_reg         <= '0;
      sym_reg         <= '0;
      done_pend_reg   <= 1'b0;
      oval_reg        <= 1'b0;
      osop_reg        <= 1'b0;
      oeop_reg        <= 1'b0;
      oframe_done_reg <= 1'b0;
      oresync_reg     <= 1'b0;
      odata_i_reg     <= '0;
      odata_q_reg     <= '0;
      osym_idx_reg    <= '0;
    end else begin
      oval_reg        <= 1'b0;
      osop_reg        <= 1'b0;
      oeop_reg        <= 1'b0;
      oresync_reg     <= 1'b0;
      done_pend_reg   <= 1'b0;
      oframe_done_reg <= done_pend_reg;
      if (accept) begin
        // The isop sample is CP sample 0 of symbol 0, whatever state we were in.
        nfft_reg    <= nfft_in;
        cp_reg      <= cp_in;
        adv_reg     <= adv_in;
        sym_reg     <= '0;
        oresync_reg <= (state_reg != IDLE);
        if (head_in == '0) begin
          state_reg    <= PASS;
          cnt_reg      <= N_ONE;
          oval_reg     <= 1'b1;
          osop_reg     <= 1'b1;
          odata_i_reg  <= bus.idata_i;
          odata_q_reg  <= bus.idata_q;
          osym_idx_reg <= '0;
        end else if (head_in == A_ONE) begin
          state_reg <= PASS;
          cnt_reg   <= '0;
        end else begin
          state_reg <= HEAD;
          cnt_reg   <= N_ONE;
        end
      end else if (bus.ival) begin
        case (state_reg)
          HEAD: begin
            if (last_head) begin
              state_reg <= PASS;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          PASS: begin
            oval_reg     <= 1'b1;
            osop_reg     <= (cnt_reg == '0);
            oeop_reg     <= last_pass;
            odata_i_reg  <= bus.idata_i;
            odata_q_reg  <= bus.idata_q;
            osym_idx_reg <= sym_reg;
            cnt_reg      <= last_pass ? '0 : cnt_inc;
            if (last_pass) state_reg <= TAIL;
          end
          TAIL: cnt_reg <= cnt_inc;
          default: ;
        endcase
        // Symbol boundary overrides the per-state update above.
        if (sym_end) begin
          cnt_reg <= '0;
          if (sym_reg == SYM_LAST) begin
            state_reg     <= IDLE;
            sym_reg       <= '0;
            done_pend_reg <= 1'b1;
          end else begin
            sym_reg   <= sym_reg + 7'd1;
            state_reg <= (head_len == '0) ? PASS : HEAD;
          end
        end
      end
    end
  end

  assign bus.oval        = oval_reg;
  assign bus.osop        = osop_reg;
  assign bus.oeop        = oeop_reg;
  assign bus.odata_i     = odata_i_reg;
  assign bus.odata_q     = odata_q_reg;
  assign bus.osym_idx    = osym_idx_reg;
  assign bus.oframe_done = oframe_done_reg;
  assign bus.oresync     = oresync_reg;
endmodule

// File: tb/tb_rmcp_frame_ctrl.sv
// Self-checking bench for rmcp_frame_ctrl: table-driven frame runs plus resync/reset sequences,
// with an arithmetic window model feeding a scoreboard queue.
module tb_rmcp_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rmcp_frame_ctrl_if #(.pDAT_W(12), .pADV_W(6)) bus ();

  rmcp_frame_ctrl #(
    .pDAT_W(12), .pNFFT_MAX(1024), .pCP_MAX(32), .pSB_NUM(50), .pADV_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] di;
    logic [11:0] dq;
    logic        sop;
    logic        eop;
    logic [6:0]  sym;
  } exp_t;

  typedef struct {
    int bw;
    int adv;
    int duty;
    int nsamp;
    int nfft;
    int cp;
    int adv_eff;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[4];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_due = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_cycle(input bit exp_val, input bit exp_rs);
    exp_t e;
    chk("oval", 64'(bus.oval), 64'(exp_val));
    if (exp_val) begin
      e = sb_q.pop_front();
      if (bus.oval)
        chk("sample", 64'({bus.odata_q, bus.odata_i, bus.osop, bus.oeop, bus.osym_idx}),
            64'({e.dq, e.di, e.sop, e.eop, e.sym}));
    end
    chk("oframe_done", 64'(bus.oframe_done), 64'(cyc == done_due));
    chk("oresync", 64'(bus.oresync), 64'(exp_rs));
  endtask

  task automatic drive_junk();
    bus.idata_i  = 12'($urandom);
    bus.idata_q  = 12'($urandom);
    bus.index_bw = 2'($urandom);
    bus.iadv     = 6'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.ival = 1'b1;
    bus.isop = 1'b1;
    drive_junk();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      chk("reset_outputs",
          64'({bus.oval, bus.osop, bus.oeop, bus.odata_i, bus.odata_q,
               bus.osym_idx, bus.oframe_done, bus.oresync}), 64'(0));
    end
    rst = 1'b0;
    bus.ival = 1'b0;
    bus.isop = 1'b0;
    sb_q.delete();
    done_due = -1;
  endtask

  task automatic idle_cycles(input int n, input bit v);
    for (int i = 0; i < n; i++) begin
      bus.ival = v;
      bus.isop = 1'b0;
      drive_junk();
      @(posedge clk); #1; cyc++;
      check_cycle(1'b0, 1'b0);
    end
  endtask

  // Drives one frame of nsamp accepted samples (isop on the first) with ramp data.
  task automatic run_frame(input int bw, input int adv, input int duty, input int nsamp,
                           input int nfft, input int cp, input int adv_eff, input bit resync);
    int   acc;
    int   slen;
    int   head;
    int   s;
    int   r;
    bit   v;
    bit   exp_val;
    bit   exp_rs;
    exp_t e;
    acc  = 0;
    slen = cp + nfft;
    head = cp - adv_eff;
    while (acc < nsamp) begin
      exp_val = 1'b0;
      exp_rs  = 1'b0;
      v = (duty >= 100) || ($urandom_range(0, 99) < duty);
      drive_junk();
      bus.ival = v;
      bus.isop = v && (acc == 0);
      if (v) begin
        bus.idata_i = 12'(acc);
        bus.idata_q = 12'(acc * 7 + 3);
        if (acc == 0) begin
          bus.index_bw = 2'(bw);
          bus.iadv     = 6'(adv);
          exp_rs       = resync;
        end
        s = acc / slen;
        r = acc % slen;
        if (s < 50 && r >= head && r < head + nfft) begin
          e.di  = 12'(acc);
          e.dq  = 12'(acc * 7 + 3);
          e.sop = (r == head);
          e.eop = (r == head + nfft - 1);
          e.sym = 7'(s);
          sb_q.push_back(e);
          exp_val = 1'b1;
        end
        if (acc == 50 * slen - 1) done_due = cyc + 2;
        acc++;
      end
      @(posedge clk); #1; cyc++;
      check_cycle(exp_val, exp_rs);
    end
  endtask

  initial begin
    tbl[0] = '{bw:0, adv:0,  duty:100, nsamp:52800, nfft:1024, cp:32, adv_eff:0};
    tbl[1] = '{bw:2, adv:3,  duty:100, nsamp:800,   nfft:256,  cp:8,  adv_eff:3};
    tbl[2] = '{bw:0, adv:40, duty:100, nsamp:2200,  nfft:1024, cp:32, adv_eff:32};
    tbl[3] = '{bw:1, adv:5,  duty:50,  nsamp:1700,  nfft:512,  cp:16, adv_eff:5};

    bus.ival = 1'b0;
    bus.isop = 1'b0;
    drive_junk();

    for (int i = 0; i < 4; i++) begin
      do_reset(3);
      idle_cycles(2, 1'b1);
      run_frame(tbl[i].bw, tbl[i].adv, tbl[i].duty, tbl[i].nsamp,
                tbl[i].nfft, tbl[i].cp, tbl[i].adv_eff, 1'b0);
      idle_cycles(3, 1'b0);
    end

    // Resync at symbol 7, window sample 100, then reset mid-PASS of the new frame.
    do_reset(2);
    run_frame(0, 0, 100, 7 * 1056 + 32 + 100, 1024, 32, 0, 1'b0);
    run_frame(0, 0, 100, 1100, 1024, 32, 0, 1'b1);
    do_reset(3);
    idle_cycles(5, 1'b1);
    run_frame(3, 2, 100, 6600, 128, 4, 2, 1'b0);
    idle_cycles(3, 1'b0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rmcp_frame_ctrl.md
# rmcp_frame_ctrl

Parametrised cyclic-prefix removal and symbol framer for the OFDM receive chain. It sits between frame synchronisation and the FFT. From a frame-start strobe it strips the CP from each OFDM symbol of a frame and emits only the FFT window, with SOP, EOP and symbol-index tags. FFT size and CP length scale with the bandwidth index. The window can be advanced into the CP to absorb timing jitter. A strobe arriving mid-frame causes a resync.

## Interface
- pDAT_W, 12 — I/Q sample width
- pNFFT_MAX, 1024 — FFT size at index_bw = 0 (power of 2)
- pCP_MAX, 32 — CP length at index_bw = 0 (power of 2, ≥ 8)
- pSB_NUM, 50 — OFDM symbols per frame
- pADV_W, 6 — width of the window-advance input
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ival  in  1  input sample valid
- isop  in  1  frame start; qualified by ival; marks CP sample 0 of symbol 0
- idata_i, idata_q  in  pDAT_W  input samples (signed)
- index_bw  in  2  bandwidth index: NFFT = pNFFT_MAX>>index_bw, CP = pCP_MAX>>index_bw; sampled at accepted isop
- iadv  in  pADV_W  samples by which the window is advanced into the CP (unsigned); sampled at accepted isop
- oval  out  1  output sample valid
- osop  out  1  first sample of a symbol's FFT window
- oeop  out  1  last sample of a symbol's FFT window
- odata_i, odata_q  out  pDAT_W  output samples
- osym_idx  out  7  symbol index within the frame, 0..pSB_NUM-1, aligned with oval
- oframe_done  out  1  one-cycle pulse after the last window sample of the frame
- oresync  out  1  one-cycle pulse when isop is accepted while a frame is active

## Operation
- Only cycles with ival=1 advance counters. Cycles with ival=0 freeze all state and drive oval=0.
- The following are latched at accepted isop (ival & isop):
  - nfft_l = pNFFT_MAX>>index_bw
  - cp_l = pCP_MAX>>index_bw
  - adv_l = min(iadv, cp_l)
- FSM states: IDLE, HEAD, PASS, TAIL. Each symbol occupies exactly cp_l + nfft_l accepted samples.
  - IDLE: wait for accepted isop. The isop sample is CP sample 0.
    - If cp_l − adv_l > 0, go to HEAD. The isop sample counts as head sample 1.
    - Otherwise go to PASS. The isop sample is window sample 0.
  - HEAD: discard samples until cp_l − adv_l head samples have been consumed, then go to PASS.
  - PASS: forward nfft_l samples.
    - First forwarded sample → osop.
    - nfft_l-th forwarded sample → oeop.
    - After the last one: if adv_l > 0, go to TAIL; otherwise start the next symbol's HEAD/PASS directly.
  - TAIL: discard adv_l samples (they belong to the symbol). Then start the next symbol.
- Symbol counter:
  - Increments at the end of each symbol.
  - After symbol pSB_NUM−1 completes (end of its TAIL, or at its oeop if adv_l = 0), go to IDLE.
  - oframe_done is pulsed on the cycle following that completion.
- Accepted isop in any state other than IDLE:
  - Abort the current frame and pulse oresync.
  - Relatch nfft_l/cp_l/adv_l and treat the sample as CP sample 0 of a new frame, with identical rules to IDLE.
  - Any partially forwarded window is truncated: no oeop is issued for it.
- isop while in IDLE with ival=0 is ignored.
- Changes to index_bw or iadv mid-frame have no effect until the next accepted isop.
- Outputs are registered. odata_* holds the last forwarded value when oval=0.

## Timing
- Latency: an input sample forwarded on cycle t appears at oval/odata on cycle t+1. osop, oeop and osym_idx are aligned with it.
- Reset: on rst=1, on the next edge:
  - FSM goes to IDLE.
  - All counters go to 0.
  - oval, osop, oeop, oframe_done and oresync go to 0.
  - odata_i, odata_q and osym_idx go to 0.
  - rst overrides a simultaneous isop.
- Reset mid-frame discards the frame. No oeop or oframe_done is issued.
- oframe_done and oresync are never asserted together. If the isop coincides with the last sample of a frame, only oresync fires.
- Continuous ival, bw=0, adv=0: first oval 33 cycles after the isop cycle. Frame length is pSB_NUM·1056 samples.

## Test plan
- bw=0, iadv=0, continuous ival, ramp data 0,1,2…
  - osop on input sample 32; oeop on 1055.
  - 50 windows of 1024; osym_idx 0..49.
  - oframe_done one cycle after the final oeop.
- bw=2, iadv=3:
  - NFFT 256, CP 8. Window begins at input sample 5; each symbol spans 264 samples.
  - Next osop at input sample 269.
- iadv=40, bw=0:
  - Clamped to 32. osop is asserted on the isop sample's output (1-cycle latency).
  - Tail discards 32 samples.
- Random ival gaps (50% duty):
  - Output sample sequence identical to the gap-free run.
  - oval=0 on every gap.
- isop accepted at symbol 7, window sample 100:
  - oresync pulse; no oeop for symbol 7.
  - New frame restarts with osym_idx=0; osop 32 samples later.
- rst asserted mid-PASS, then isop 5 cycles after release:
  - All outputs 0 during reset.
  - Clean frame thereafter.
